// File: rtl/sdiv_pkg.sv
// Shared types and constants for the sequential signed divider (sdiv16x8_seq).
package sdiv_pkg;

    localparam int DVD_W_DEF = 16;
    localparam int DVS_W_DEF = 8;

    localparam logic [DVD_W_DEF-1:0] QPOS_SAT = 16'h7FFF;
    localparam logic [DVD_W_DEF-1:0] QNEG_SAT = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } sdiv_state_e;

    // Width of a down-counter that must hold the value `iters`.
    function automatic int cnt_w(input int iters);
        return $clog2(iters + 1);
    endfunction

endpackage

// File: rtl/sdiv_step.sv
// One restoring-division step on magnitudes: shift in the next dividend bit,
// subtract the divisor magnitude when it fits.
module sdiv_step #(
    parameter int DVS_W = 8
) (
    input  logic [DVS_W:0]   i_prem,
    input  logic             i_din,
    input  logic [DVS_W-1:0] i_bmag,
    output logic [DVS_W:0]   o_prem,
    output logic             o_qbit
);

    logic [DVS_W:0] w_sh;
    logic           w_ge;

    assign w_sh = {i_prem[DVS_W-1:0], i_din};
    // A set top bit of prem would shift out beyond any divisor, so it forces a subtract.
    assign w_ge = i_prem[DVS_W] | (w_sh >= {1'b0, i_bmag});

    assign o_qbit = w_ge;
    assign o_prem = w_ge ? (w_sh - {1'b0, i_bmag}) : w_sh;

endmodule

// File: rtl/sdiv16x8_seq.sv
// Sequential signed divider, restoring on magnitudes with final sign fix-up.
// Define SDIV_RADIX4_EN to retire two quotient bits per CALC cycle.
module sdiv16x8_seq
    import sdiv_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_zero,
    output logic             ovf
);

`ifdef SDIV_RADIX4_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif
    localparam int ITERS = DVD_W / STEPS;
    localparam int CW    = cnt_w(ITERS);

    localparam logic [CW-1:0]    L_ITERS = CW'(ITERS);
    localparam logic [CW-1:0]    L_ONE   = CW'(1);
    localparam logic [DVD_W-1:0] L_QPOS  = {1'b0, {(DVD_W-1){1'b1}}};
    localparam logic [DVD_W-1:0] L_QNEG  = {1'b1, {(DVD_W-1){1'b0}}};

    sdiv_state_e      r_state;
    logic             r_sign_a;
    logic             r_sign_b;
    logic [DVS_W-1:0] r_bmag;
    logic [DVS_W:0]   r_prem;
    logic [DVD_W-1:0] r_qreg;
    logic [CW-1:0]    r_cnt;
    logic [DVD_W-1:0] r_quot;
    logic [DVS_W-1:0] r_rem;
    logic             r_div_zero;
    logic             r_ovf;

    logic [DVD_W-1:0] w_amag;
    logic [DVS_W-1:0] w_bmag;
    logic             w_dvs_zero;
    logic             w_sat;
    logic [DVS_W:0]   w_prem0;
    logic             w_qb0;
    logic [DVS_W:0]   w_prem_nxt;
    logic [DVD_W-1:0] w_qreg_nxt;

    assign w_amag     = dividend[DVD_W-1] ? -dividend : dividend;
    assign w_bmag     = divisor[DVS_W-1]  ? -divisor  : divisor;
    assign w_dvs_zero = (divisor == '0);
    assign w_sat      = (dividend == L_QNEG) && (divisor == '1);

    // qreg holds the unconsumed dividend bits at the top and grows quotient bits at the bottom.
    sdiv_step #(.DVS_W(DVS_W)) u_step0 (
        .i_prem (r_prem),
        .i_din  (r_qreg[DVD_W-1]),
        .i_bmag (r_bmag),
        .o_prem (w_prem0),
        .o_qbit (w_qb0)
    );

`ifdef SDIV_RADIX4_EN
    logic [DVS_W:0] w_prem1;
    logic           w_qb1;

    sdiv_step #(.DVS_W(DVS_W)) u_step1 (
        .i_prem (w_prem0),
        .i_din  (r_qreg[DVD_W-2]),
        .i_bmag (r_bmag),
        .o_prem (w_prem1),
        .o_qbit (w_qb1)
    );

    assign w_prem_nxt = w_prem1;
    assign w_qreg_nxt = {r_qreg[DVD_W-3:0], w_qb0, w_qb1};
`else
    assign w_prem_nxt = w_prem0;
    assign w_qreg_nxt = {r_qreg[DVD_W-2:0], w_qb0};
`endif

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state    <= IDLE;
            r_sign_a   <= 1'b0;
            r_sign_b   <= 1'b0;
            r_bmag     <= '0;
            r_prem     <= '0;
            r_qreg     <= '0;
            r_cnt      <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign_a   <= dividend[DVD_W-1];
                        r_sign_b   <= divisor[DVS_W-1];
                        r_bmag     <= w_bmag;
                        r_qreg     <= w_amag;
                        r_prem     <= '0;
                        r_cnt      <= L_ITERS;
                        r_div_zero <= 1'b0;
                        r_ovf      <= 1'b0;
                        if (w_dvs_zero) begin
                            r_quot     <= dividend[DVD_W-1] ? L_QNEG : L_QPOS;
                            r_rem      <= dividend[DVS_W-1:0];
                            r_div_zero <= 1'b1;
                            r_state    <= DONE;
                        end else if (w_sat) begin
                            r_quot  <= L_QPOS;
                            r_rem   <= '0;
                            r_ovf   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_prem <= w_prem_nxt;
                    r_qreg <= w_qreg_nxt;
                    r_cnt  <= r_cnt - L_ONE;
                    if (r_cnt == L_ONE) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_quot  <= (r_sign_a ^ r_sign_b) ? -r_qreg : r_qreg;
                    r_rem   <= r_sign_a ? -r_prem[DVS_W-1:0] : r_prem[DVS_W-1:0];
                    r_state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign div_zero  = r_div_zero;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_sdiv16x8_seq.sv
// Self-checking bench for sdiv16x8_seq: directed table, flag paths, backpressure,
// mid-operation reset, random operands against an integer-arithmetic model.
module tb_sdiv16x8_seq;
    import sdiv_pkg::*;

`ifdef SDIV_RADIX4_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 18;
`endif
    localparam int THRU = LAT + 1;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [7:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;
    logic        ovf;

    int n_checks = 0;
    int n_pass = 0;

    sdiv16x8_seq dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .dividend        (dividend),
        .divisor         (divisor),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .quotient        (quotient),
        .remainder       (remainder),
        .div_zero        (div_zero),
        .ovf             (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain signed integer division (truncating, remainder takes dividend sign).
    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [15:0] q, output logic [7:0] r,
                                  output logic dz, output logic ov);
        int sa, sb;
        sa = int'($signed(a));
        sb = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            q  = (sa >= 0) ? QPOS_SAT : QNEG_SAT;
            r  = a[7:0];
            dz = 1'b1;
        end else if (sa == -32768 && sb == -1) begin
            q  = QPOS_SAT;
            r  = 8'h00;
            ov = 1'b1;
        end else begin
            q = 16'(sa / sb);
            r = 8'(sa % sb);
        end
    endfunction

    // Drive one operand pair; lat counts edges from the accept edge (=1) to out_valid.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int lat);
        int guard;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic ack();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if ({out_valid, div_zero, ovf} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {out_valid, div_zero, ovf}); else n_pass++;
        n_checks++; if ({quotient, remainder} !== 24'h0) $display("FAIL reset_data: got %h want 000000", {quotient, remainder}); else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_vectors();
        logic [15:0] ta [7] = '{16'd100, 16'hFF9C, 16'd100, 16'h8000, 16'h8000, 16'h04D2, 16'hFFFB};
        logic [7:0]  tb [7] = '{8'd7, 8'd7, 8'hF9, 8'hFF, 8'h80, 8'h00, 8'h00};
        logic [15:0] tq [7] = '{16'h000E, 16'hFFF2, 16'hFFF2, 16'h7FFF, 16'h0100, 16'h7FFF, 16'h8000};
        logic [7:0]  tr [7] = '{8'h02, 8'hFE, 8'h02, 8'h00, 8'h00, 8'hD2, 8'hFB};
        logic [1:0]  tf [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b10};
        int lat, elat;
        for (int i = 0; i < 7; i++) begin
            run_op(ta[i], tb[i], lat);
            elat = (tf[i] != 2'b00) ? 1 : LAT;
            n_checks++; if (quotient !== tq[i]) $display("FAIL vec%0d_quot: got %h want %h", i, quotient, tq[i]); else n_pass++;
            n_checks++; if (remainder !== tr[i]) $display("FAIL vec%0d_rem: got %h want %h", i, remainder, tr[i]); else n_pass++;
            n_checks++; if ({div_zero, ovf} !== tf[i]) $display("FAIL vec%0d_flags: got %b want %b", i, {div_zero, ovf}, tf[i]); else n_pass++;
            n_checks++; if (lat != elat) $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, elat); else n_pass++;
            ack();
        end
    endtask

    task automatic test_hold();
        int lat;
        run_op(16'd100, 8'd7, lat);
        @(negedge clk);
        dividend = 16'd50;
        divisor  = 8'd3;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++; if ({out_valid, in_ready} !== 2'b10) $display("FAIL hold_hs%0d: got %b want 10", i, {out_valid, in_ready}); else n_pass++;
            n_checks++; if ({quotient, remainder} !== 24'h000E02) $display("FAIL hold_data%0d: got %h want 000E02", i, {quotient, remainder}); else n_pass++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        n_checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL hold_return_idle: got %b want 10", {in_ready, out_valid}); else n_pass++;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL hold_pending_accept: got %b want 0", in_ready); else n_pass++;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        n_checks++; if (lat != LAT) $display("FAIL hold_pending_latency: got %0d want %0d", lat, LAT); else n_pass++;
        n_checks++; if ({quotient, remainder} !== 24'h001002) $display("FAIL hold_pending_result: got %h want 001002", {quotient, remainder}); else n_pass++;
        ack();
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        edz, eov;
        run_op(16'd30000, 8'hF9, lat);
        ack();
        @(negedge clk);
        dividend = 16'd12345;
        divisor  = 8'd11;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        n_checks++; if ({out_valid, in_ready, div_zero, ovf} !== 4'b0100) $display("FAIL rstmid_ctrl: got %b want 0100", {out_valid, in_ready, div_zero, ovf}); else n_pass++;
        n_checks++; if ({quotient, remainder} !== 24'h0) $display("FAIL rstmid_data: got %h want 000000", {quotient, remainder}); else n_pass++;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if ({in_ready, out_valid} !== 2'b10) $display("FAIL rstmid_release: got %b want 10", {in_ready, out_valid}); else n_pass++;
        model(16'hE0C0, 8'd9, eq, er, edz, eov);
        run_op(16'hE0C0, 8'd9, lat);
        n_checks++; if ({quotient, remainder} !== {eq, er}) $display("FAIL rstmid_next: got %h want %h", {quotient, remainder}, {eq, er}); else n_pass++;
        n_checks++; if (lat != LAT) $display("FAIL rstmid_next_latency: got %0d want %0d", lat, LAT); else n_pass++;
        ack();
    endtask

    task automatic test_random();
        logic [15:0] a, eq;
        logic [7:0]  b, er;
        logic        edz, eov;
        int lat, elat;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = 8'($urandom);
            case ($urandom_range(0, 7))
                0: b = 8'h00;
                1: b = 8'hFF;
                2: b = 8'h80;
                3: a = 16'h8000;
                4: b = 8'h01;
                default: ;
            endcase
            model(a, b, eq, er, edz, eov);
            elat = (edz | eov) ? 1 : LAT;
            run_op(a, b, lat);
            n_checks++; if (quotient !== eq) $display("FAIL rand%0d_quot: %h/%h got %h want %h", i, a, b, quotient, eq); else n_pass++;
            n_checks++; if (remainder !== er) $display("FAIL rand%0d_rem: %h/%h got %h want %h", i, a, b, remainder, er); else n_pass++;
            n_checks++; if ({div_zero, ovf} !== {edz, eov}) $display("FAIL rand%0d_flags: got %b want %b", i, {div_zero, ovf}, {edz, eov}); else n_pass++;
            n_checks++; if (lat != elat) $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, elat); else n_pass++;
            ack();
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int guard;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        edz, eov;
        model(16'd1000, 8'hFD, eq, er, edz, eov);
        @(negedge clk);
        dividend  = 16'd1000;
        divisor   = 8'hFD;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int e = 0; e < 3 * THRU + 2; e++) begin
            @(negedge clk);
            if (in_ready) acc.push_back(e);
            if (out_valid) begin
                n_checks++; if ({quotient, remainder} !== {eq, er}) $display("FAIL b2b_result: got %h want %h", {quotient, remainder}, {eq, er}); else n_pass++;
            end
        end
        in_valid = 1'b0;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        n_checks++; if (acc.size() < 3) $display("FAIL b2b_accepts: got %0d want >=3", acc.size()); else n_pass++;
        for (int k = 1; k < acc.size(); k++) begin
            n_checks++; if (acc[k] - acc[k-1] != THRU) $display("FAIL b2b_interval%0d: got %0d want %0d", k, acc[k] - acc[k-1], THRU); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
